cla_pipe_adder: RTL and testbench
=================================

# cla_pipe_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from per-bit propagate/generate logic, with a valid/ready stream interface. It is the successor to the single-bit adder cell: WIDTH bits, grouped lookahead, a subtract mode, signed overflow detection and back-pressure. It sits in the datapath between operand registers and any consumer that can stall.

## Interface

- WIDTH, 16: operand/result width; must be a multiple of GROUP and at least GROUP.
- GROUP, 4: lookahead group size in bits; must be at least 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; during subtract it acts as borrow-in.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; during subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation

- Effective operand: bx = sub ? ~b : b; carry c0 = cin ^ sub.
- Per bit: p[i] = a[i]^bx[i], g[i] = a[i]&bx[i] (true propagate/generate).
- Per group: GP = AND of member p; GG = lookahead generate over members.
- Stage 1 registers p, g, GP, GG, c0, a[WIDTH-1], bx[WIDTH-1] and valid v1.
- Stage 2 computes group carries C[k+1] = GG[k] | GP[k]&C[k], with C[0] = c0. It then forms in-group carries and sum[i] = p[i]^c[i]. It registers sum, cout = c[WIDTH], ovf = c[WIDTH]^c[WIDTH-1], and out_valid.
- Global stall: adv = !out_valid | out_ready; in_ready = adv.
- When adv is 1: stage 2 loads from stage 1 (out_valid <= v1), and stage 1 loads the inputs (v1 <= in_valid).
- When adv is 0: every register holds, including v1 and the stage-1 data.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Results leave in acceptance order. The block never drops or duplicates a result.
- Operand bits registered while valid is 0 have no meaning.

## Timing

- Latency: a transfer accepted at edge N appears with out_valid = 1 after edge N+1, given no stall. With out_ready held high, throughput is one result per cycle.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- While out_valid = 1 and out_ready = 0, sum, cout and ovf are stable, and in_ready = 0.
- Simultaneous out_ready = 1 and in_valid = 1 on a full pipeline: the output is consumed, stage 1 advances and the new input is accepted in the same cycle.
- Reset, including assertion mid-operation: v1 = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0. In-flight data is discarded immediately, asynchronously.
- Reset values of data registers are 0.
- After release, in_ready = 1 in the first cycle.
- Boundary cases: GROUP = WIDTH gives a single group, which is ripple-within-group. GROUP = 1 gives full lookahead. Both must give identical results.

## Configuration

- CLA_SAT_EN defined: on ovf = 1, sum saturates to the signed limit. The result is 0111..1 when the true result is positive (a[WIDTH-1] = 0) and 1000..0 otherwise. ovf is still reported as 1, and cout is unchanged.
- CLA_SAT_EN undefined: sum wraps modulo 2^WIDTH.
- Latency and handshake are identical in both builds.

## Test plan

- Defaults, no macro, add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0, out_valid one edge after acceptance.
- Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1. Same stimulus with CLA_SAT_EN -> sum=0x7FFF, ovf=1.
- Subtract 0x0005-0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, ovf=1. The latter gives sum=0x8000 with CLA_SAT_EN.
- Stream 1+1, 2+2, 3+3 back-to-back and hold out_ready=0 for 2 cycles after the first result -> in_ready=0 during the stall, sum held at 0x0002, then 0x0004 and 0x0006 in order, with no loss.
- Assert rst_n low with both stages valid -> out_valid=0 and sum=0 immediately. After release, 0x1234+0x1111 -> 0x2345 with in_ready=1 in the first cycle.
- Random 10k operand/sub/cin vectors at GROUP=1, 4 and 16, with random out_ready -> every result matches the reference a±b±cin, and cout/ovf match.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- two-stage pipelined carry-lookahead adder/subtractor.
//
// Stage 1 forms per-bit propagate/generate on the effective operand
// (b, or ~b when subtracting) and folds them into per-group propagate and
// generate. Stage 2 resolves the group carries, ripples inside each group,
// and registers sum, carry-out and signed overflow. One global advance
// signal stalls both stages together when the consumer back-pressures.
//
// Parameters:
//   WIDTH  operand/result width; a multiple of GROUP and at least GROUP
//   GROUP  lookahead group size in bits; at least 1
//            GROUP = 1      -> full lookahead
//            GROUP = WIDTH  -> single group, ripple within the group
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; discards in-flight data
//   in_valid   operands present this cycle
//   in_ready   block accepts operands this cycle (= !out_valid | out_ready)
//   a, b       operands
//   cin        carry-in (borrow-in when sub = 1)
//   sub        0: a + b + cin   1: a - b - cin
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry-out (when sub = 1, 1 means no borrow)
//   ovf        two's-complement signed overflow
//
// Build option:
//   CLA_SAT_EN  when defined, a result with ovf = 1 saturates to the signed
//               limit in the direction of the true result; otherwise the sum
//               wraps modulo 2^WIDTH. Latency and handshake do not change.

module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;

  // Both stages move together; a full, stalled output freezes everything.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- stage 1
  logic [WIDTH-1:0] bx, p_d, g_d;
  logic [NG-1:0]    gp_d, gg_d;
  logic             c0_d;

  always_comb begin : s1_pg
    logic acc;
    bx   = sub ? ~b : b;
    c0_d = cin ^ sub;
    p_d  = a ^ bx;
    g_d  = a & bx;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[k*GROUP +: GROUP];
      // NOTE: blocking assignments here build a combinational chain; each
      // iteration sees the value the previous one just produced, folding the
      // group's generate from its LSB up to its MSB.
      acc = 1'b0;
      for (int j = 0; j < GROUP; j++)
        acc = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & acc);
      gg_d[k] = acc;
    end
  end

  logic             v1;
  logic [WIDTH-1:0] p_q, g_q;
  logic [NG-1:0]    gp_q, gg_q;
  logic             c0_q, a_msb_q, bx_msb_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is asynchronous and clears data as well as
  // valid so a reset mid-operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      gp_q     <= '0;
      gg_q     <= '0;
      c0_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      bx_msb_q <= 1'b0;
    end else if (adv) begin
      v1       <= in_valid;
      p_q      <= p_d;
      g_q      <= g_d;
      gp_q     <= gp_d;
      gg_q     <= gg_d;
      c0_q     <= c0_d;
      a_msb_q  <= a[WIDTH-1];
      bx_msb_q <= bx[WIDTH-1];
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [NG:0]      gc;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  always_comb begin
    gc    = '0;
    c     = '0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++)
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
    // Each group starts from its lookahead carry and ripples internally; the
    // carry out of the top group comes from the lookahead chain.
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int j = 0; j < GROUP - 1; j++)
        c[k*GROUP+j+1] = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & c[k*GROUP+j]);
    end
    c[WIDTH] = gc[NG];
    sum_d    = p_q ^ c[WIDTH-1:0];
    // Overflow needs equal effective operand signs; the carry test alone
    // already implies that, the qualifier only makes the intent explicit.
    ovf_d    = (a_msb_q ~^ bx_msb_q) & (c[WIDTH] ^ c[WIDTH-1]);
`ifdef CLA_SAT_EN
    // On overflow both operand signs agree, so a's sign is the sign of the
    // true (unbounded) result: negative clamps to 100..0, positive to 011..1.
    if (ovf_d)
      sum_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    // Wrapping build: sum_d is already the result modulo 2^WIDTH.
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= v1;
      sum       <= sum_d;
      cout      <= c[WIDTH];
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder. Three instances (GROUP = 4, 1, 16) share
// the same stimulus; directed vectors carry hand-computed results, and a
// random phase compares every instance against a cycle-level pipeline model
// built on an integer reference of a +/- b +/- cin.

module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_ready;

  logic         in_ready  [3];
  logic         out_valid [3];
  logic [W-1:0] sum       [3];
  logic         cout      [3];
  logic         ovf       [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) u_g4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));

  cla_pipe_adder #(.WIDTH(W), .GROUP(1)) u_g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));

  cla_pipe_adder #(.WIDTH(W), .GROUP(16)) u_g16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

  // Instance index -> group size, for readable tags.
  function automatic int gsize(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 16;
  endfunction

`ifdef CLA_SAT_EN
  localparam logic [W-1:0] OVF_ADD_SUM = 16'h7FFF;  // 0x7FFF + 1 clamps high
  localparam logic [W-1:0] OVF_SUB_SUM = 16'h8000;  // 0x8000 - 1 clamps low
`else
  localparam logic [W-1:0] OVF_ADD_SUM = 16'h8000;
  localparam logic [W-1:0] OVF_SUB_SUM = 16'h7FFF;
`endif

  task automatic check_word(input string tag, input logic [W-1:0] obs,
                            input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      $error("%s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Output side of all three instances against one expectation.
  task automatic check_out(input string tag, input logic ev,
                           input logic [W-1:0] es, input logic ec,
                           input logic eo);
    for (int i = 0; i < 3; i++) begin
      check_bit ($sformatf("%s.g%0d.out_valid", tag, gsize(i)), out_valid[i], ev);
      check_word($sformatf("%s.g%0d.sum",       tag, gsize(i)), sum[i],       es);
      check_bit ($sformatf("%s.g%0d.cout",      tag, gsize(i)), cout[i],      ec);
      check_bit ($sformatf("%s.g%0d.ovf",       tag, gsize(i)), ovf[i],       eo);
    end
  endtask

  task automatic check_ready(input string tag, input logic er);
    for (int i = 0; i < 3; i++)
      check_bit($sformatf("%s.g%0d.in_ready", tag, gsize(i)), in_ready[i], er);
  endtask

  task automatic check_valid(input string tag, input logic ev);
    for (int i = 0; i < 3; i++)
      check_bit($sformatf("%s.g%0d.out_valid", tag, gsize(i)), out_valid[i], ev);
  endtask

  // One isolated transfer with out_ready high: accepted at edge N, visible
  // only after edge N+1.
  task automatic single(input string tag, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic xcin,
                        input logic xsub, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    @(negedge clk);
    a = xa; b = xb; cin = xcin; sub = xsub; in_valid = 1'b1; out_ready = 1'b1;
    #1 check_ready({tag, ".accept"}, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_valid({tag, ".early"}, 1'b0);
    @(negedge clk);
    #1 check_out(tag, 1'b1, es, ec, eo);
  endtask

  // Integer reference: {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] xa,
                                             input logic [W-1:0] xb,
                                             input logic xcin, input logic xsub);
    logic [W:0]   full;
    logic [W-1:0] s;
    int           r;
    logic         ov;
    if (xsub) begin
      full = {1'b0, xa} + {1'b0, ~xb} + {{W{1'b0}}, ~xcin};
      r    = int'($signed(xa)) - int'($signed(xb)) - (xcin ? 1 : 0);
    end else begin
      full = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xcin};
      r    = int'($signed(xa)) + int'($signed(xb)) + (xcin ? 1 : 0);
    end
    ov = (r > 32767) || (r < -32768);
    s  = full[W-1:0];
`ifdef CLA_SAT_EN
    if (ov) s = xa[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, full[W], s};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [4];
    corners = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(7) == 0) return corners[$urandom_range(3)];
    return W'($urandom);
  endfunction

  // Pipeline model state for the random phase.
  logic         v1m, ovm;
  logic [W+1:0] r1m, r2m;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    #1 check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_ready("reset.release", 1'b1);

    // Directed single transfers.
    single("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("add_7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, OVF_ADD_SUM, 1'b0, 1'b1);
    single("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, OVF_SUB_SUM, 1'b1, 1'b1);
    single("add_cin",     16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
    single("sub_borrow",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
    single("add_neg_ovf", 16'h8000, 16'hFFFF, 1'b0, 1'b0,
           OVF_SUB_SUM, 1'b1, 1'b1);

    // Back-to-back stream with a two-cycle stall after the first result.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    a = 16'h0002; b = 16'h0002;
    @(negedge clk);
    a = 16'h0003; b = 16'h0003; out_ready = 1'b0;
    #1 check_out("stream.first", 1'b1, 16'h0002, 1'b0, 1'b0);
    check_ready("stream.stall0", 1'b0);
    @(negedge clk);
    #1 check_out("stream.hold1", 1'b1, 16'h0002, 1'b0, 1'b0);
    check_ready("stream.stall1", 1'b0);
    @(negedge clk);
    #1 check_out("stream.hold2", 1'b1, 16'h0002, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1 check_ready("stream.resume", 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_out("stream.second", 1'b1, 16'h0004, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_out("stream.third", 1'b1, 16'h0006, 1'b0, 1'b0);
    @(negedge clk);
    #1 check_valid("stream.drained", 1'b0);

    // Fill both stages, then reset asynchronously between edges.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0002; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    a = 16'h0100; b = 16'h0200;
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_out("full", 1'b1, 16'h0001, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_out("midreset", 1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    #1 check_ready("post_reset.ready", 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    // A surviving stage-1 entry would surface here.
    #1 check_valid("post_reset.no_stale", 1'b0);
    @(negedge clk);
    #1 check_out("post_reset.result", 1'b1, 16'h2345, 1'b0, 1'b0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Random phase against the pipeline model.
    v1m = 1'b0; ovm = 1'b0; r1m = '0; r2m = '0;
    for (int n = 0; n < 14000; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(3) != 0);
      a         = pick_operand();
      b         = pick_operand();
      cin       = 1'($urandom_range(1));
      sub       = 1'($urandom_range(1));
      out_ready = ($urandom_range(3) != 0);
      #1;
      for (int i = 0; i < 3; i++) begin
        check_bit($sformatf("rand%0d.g%0d.out_valid", n, gsize(i)),
                  out_valid[i], ovm);
        check_bit($sformatf("rand%0d.g%0d.in_ready", n, gsize(i)),
                  in_ready[i], !ovm || out_ready);
        if (ovm) begin
          check_word($sformatf("rand%0d.g%0d.sum", n, gsize(i)), sum[i], r2m[W-1:0]);
          check_bit ($sformatf("rand%0d.g%0d.cout", n, gsize(i)), cout[i], r2m[W]);
          check_bit ($sformatf("rand%0d.g%0d.ovf", n, gsize(i)), ovf[i], r2m[W+1]);
        end
      end
      if (!ovm || out_ready) begin
        ovm = v1m;
        r2m = r1m;
        v1m = in_valid;
        r1m = ref_model(a, b, cin, sub);
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
